// File: rtl/codec.sv
// Bidirectional 16-bit one-hot / 4-bit index converter on two shared tri-state buses.
// Optional macro CODEC_LSB_PRIORITY_EN: encoder reports the lowest set bit instead of the highest.
module codec (
  input  logic      CLK,
  input  logic      RESET,
  input  logic      ENCODE_,
  inout  tri [15:0] DATA,
  inout  tri [3:0]  CODE
);

  logic [3:0]  r_code_q;
  logic [15:0] r_data_q;
  logic [3:0]  w_enc_idx;
  logic [15:0] w_dec_word;

  // Later loop hits overwrite earlier ones, so scan order selects the priority end.
  always_comb begin
    w_enc_idx = 4'h0;
`ifdef CODEC_LSB_PRIORITY_EN
    for (int i = 15; i >= 0; i--) begin
      if (DATA[i]) w_enc_idx = 4'(i);
    end
`else
    for (int i = 0; i < 16; i++) begin
      if (DATA[i]) w_enc_idx = 4'(i);
    end
`endif
  end

  always_comb begin
    w_dec_word = 16'h0001 << CODE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_code_q <= 4'h0;
      r_data_q <= 16'h0000;
    end else if (ENCODE_) begin
      r_data_q <= w_dec_word;
    end else begin
      r_code_q <= w_enc_idx;
    end
  end

  assign CODE = ENCODE_ ? 4'bzzzz : r_code_q;
  assign DATA = ENCODE_ ? r_data_q : 16'hzzzz;

endmodule

// File: tb/tb_codec.sv
// Directed-vector and random reference check of codec in both modes.
// Expectations follow CODEC_LSB_PRIORITY_EN when it is defined for the build.
module tb_codec;

  logic      CLK;
  logic      RESET;
  logic      ENCODE_;
  tri [15:0] DATA;
  tri [3:0]  CODE;

  logic [15:0] tb_data;
  logic        tb_data_oe;
  logic [3:0]  tb_code;
  logic        tb_code_oe;

  assign DATA = tb_data_oe ? tb_data : 16'hzzzz;
  assign CODE = tb_code_oe ? tb_code : 4'bzzzz;

  int n_checks = 0;
  int n_pass   = 0;

  codec dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENCODE_ (ENCODE_),
    .DATA    (DATA),
    .CODE    (CODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rst;
    logic        enc_n;
    logic [15:0] data_in;
    logic [3:0]  code_in;
    logic [15:0] exp_data;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] ref_enc(input logic [15:0] w);
`ifdef CODEC_LSB_PRIORITY_EN
    for (int i = 0; i < 16; i++) if (w[i]) return 4'(i);
`else
    for (int i = 15; i >= 0; i--) if (w[i]) return 4'(i);
`endif
    return 4'h0;
  endfunction

  function automatic logic [15:0] ref_dec(input logic [3:0] c);
    logic [15:0] w;
    w = 16'h0;
    w[c] = 1'b1;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One clock: drive the input bus, release it just after the edge, check at the falling edge.
  task automatic apply(input vec_t v);
    RESET   = v.rst;
    ENCODE_ = v.enc_n;
    if (v.enc_n) begin
      tb_data_oe = 1'b0;
      tb_code    = v.code_in;
      tb_code_oe = 1'b1;
    end else begin
      tb_code_oe = 1'b0;
      tb_data    = v.data_in;
      tb_data_oe = 1'b1;
    end
    @(posedge CLK);
    #1;
    tb_data_oe = 1'b0;
    tb_code_oe = 1'b0;
    RESET      = 1'b0;
    @(negedge CLK);
    if (v.enc_n) chk(v.name, DATA, v.exp_data);
    else         chk(v.name, {12'h0, CODE}, {12'h0, v.exp_code});
  endtask

  function automatic vec_t mk(input string nm, input logic rst, input logic enc_n,
                              input logic [15:0] d, input logic [3:0] c);
    vec_t v;
    v.name = nm; v.rst = rst; v.enc_n = enc_n; v.data_in = d; v.code_in = c;
    v.exp_data = rst ? 16'h0 : ref_dec(c);
    v.exp_code = rst ? 4'h0 : ref_enc(d);
    return v;
  endfunction

  initial begin
    vec_t v;
    RESET = 1'b0; ENCODE_ = 1'b0;
    tb_data = 16'h0; tb_data_oe = 1'b0; tb_code = 4'h0; tb_code_oe = 1'b0;

    // Hand-computed expectations; the ref functions are cross-checked against these literals.
`ifdef CODEC_LSB_PRIORITY_EN
    chk("ref_8001", {12'h0, ref_enc(16'h8001)}, 16'h0000);
    chk("ref_00ff", {12'h0, ref_enc(16'h00FF)}, 16'h0000);
`else
    chk("ref_8001", {12'h0, ref_enc(16'h8001)}, 16'h000F);
    chk("ref_00ff", {12'h0, ref_enc(16'h00FF)}, 16'h0007);
`endif
    chk("ref_dec_a", ref_dec(4'hA), 16'h0400);

    vecs.push_back(mk("rst_enc",  1'b1, 1'b0, 16'hFFFF, 4'h0));
    vecs.push_back(mk("enc_8001", 1'b0, 1'b0, 16'h8001, 4'h0));
    vecs.push_back(mk("enc_0010", 1'b0, 1'b0, 16'h0010, 4'h0));
    vecs.push_back(mk("enc_0000", 1'b0, 1'b0, 16'h0000, 4'h0));
    vecs.push_back(mk("enc_00ff", 1'b0, 1'b0, 16'h00FF, 4'h0));
    vecs.push_back(mk("rst_dec",  1'b1, 1'b1, 16'h0000, 4'h7));
    vecs.push_back(mk("dec_0",    1'b0, 1'b1, 16'h0000, 4'h0));
    vecs.push_back(mk("dec_a",    1'b0, 1'b1, 16'h0000, 4'hA));
    vecs.push_back(mk("dec_f",    1'b0, 1'b1, 16'h0000, 4'hF));
    vecs.push_back(mk("dec_3",    1'b0, 1'b1, 16'h0000, 4'h3));
    vecs.push_back(mk("rst_mid",  1'b1, 1'b1, 16'h0000, 4'h4));
    vecs.push_back(mk("dec_5",    1'b0, 1'b1, 16'h0000, 4'h5));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Bus direction switches with no clock edge; held registers appear immediately.
    // code_q was cleared by the mid-stream reset, data_q holds 16'h0020.
    ENCODE_ = 1'b0;
    #1;
    chk("dir_code_held0", {12'h0, CODE}, 16'h0000);
    apply(mk("enc_1200", 1'b0, 1'b0, 16'h1200, 4'h0));
    ENCODE_ = 1'b1;
    #1;
    chk("dir_data_held", DATA, 16'h0020);
    tb_code = 4'h9; tb_code_oe = 1'b1;
    #1;
    chk("dir_code_released", {12'h0, CODE}, 16'h0009);
    tb_code_oe = 1'b0;
    ENCODE_ = 1'b0;
    #1;
`ifdef CODEC_LSB_PRIORITY_EN
    chk("dir_code_held", {12'h0, CODE}, 16'h0009);
`else
    chk("dir_code_held", {12'h0, CODE}, 16'h000C);
`endif
    tb_data = 16'hA5C3; tb_data_oe = 1'b1;
    #1;
    chk("dir_data_released", DATA, 16'hA5C3);
    tb_data_oe = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 1000; i++) begin
      v = mk("rand_enc", 1'b0, 1'b0, 16'($urandom) >> $urandom_range(15, 0), 4'h0);
      apply(v);
    end
    for (int i = 0; i < 1000; i++) begin
      v = mk("rand_dec", 1'b0, 1'b1, 16'h0, 4'($urandom_range(15, 0)));
      apply(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
